// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: button front end and mode sequencer for a digital watch.
// Three raw buttons are synchronized, debounced and turned into one-cycle
// press events, which drive a CLOCK/SET/STOPWATCH/ALARM mode machine.
module watch_mode_ctrl #(
    parameter int DB_CYC     = 20,
    parameter int BLINK_HALF = 500,
    parameter int SET_TMO    = 10000
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BTN_MODE,
    input  logic       BTN_SEL,
    input  logic       BTN_INC,
    input  logic       SW3,
    output logic [1:0] MODE,
    output logic [1:0] SET_FIELD,
    output logic       INC_PULSE,
    output logic       SW_EN,
    output logic       SW_START,
    output logic       BLINK
);

    // Counter widths cover both the normal limits and the debug limits (2/4/16).
    localparam int DB_W = $clog2((DB_CYC > 2 ? DB_CYC : 2) + 1);
    localparam int BL_W = $clog2((BLINK_HALF > 4 ? BLINK_HALF : 4) + 1);
    localparam int TM_W = $clog2((SET_TMO > 16 ? SET_TMO : 16) + 1);

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET       = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_ALARM     = 2'd3
    } mode_t;

    // Terminal counts (limit minus one); SW3 swaps in short debug limits live.
    logic [DB_W-1:0] db_max;
    logic [BL_W-1:0] blink_max;
    logic [TM_W-1:0] tmo_max;

    assign db_max    = SW3 ? DB_W'(1)  : DB_W'(DB_CYC - 1);
    assign blink_max = SW3 ? BL_W'(3)  : BL_W'(BLINK_HALF - 1);
    assign tmo_max   = SW3 ? TM_W'(15) : TM_W'(SET_TMO - 1);

    // Bit 0 = MODE, bit 1 = SEL, bit 2 = INC.
    logic [2:0]            raw;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            level;
    logic [2:0]            level_d;
    logic [2:0]            press;
    logic [2:0][DB_W-1:0]  db_cnt;

    assign raw = {BTN_INC, BTN_SEL, BTN_MODE};

    // Synchronize each button, then flip its debounced level after a stable run.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            db_cnt  <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] >= db_max) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is the cycle right after the debounced level rises.
    logic mode_ev;
    logic sel_ev;
    logic inc_ev;
    logic any_ev;

    assign press   = level & ~level_d;
    assign mode_ev = press[0];
    assign sel_ev  = press[1] & ~press[0];
    assign inc_ev  = press[2] & ~press[1] & ~press[0];
    assign any_ev  = |press;

    mode_t           mode_q, mode_n;
    logic [1:0]      field_q, field_n;
    logic [TM_W-1:0] tmo_q, tmo_n;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_n;
    logic            blink_q, blink_n;
    logic            inc_q, inc_n;
    logic            start_q, start_n;
    logic            swen_q, swen_n;

    // Mode machine state and registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mode_q      <= MODE_CLOCK;
            field_q     <= '0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b0;
            start_q     <= 1'b0;
            swen_q      <= 1'b0;
        end else begin
            mode_q      <= mode_n;
            field_q     <= field_n;
            tmo_q       <= tmo_n;
            blink_cnt_q <= blink_cnt_n;
            blink_q     <= blink_n;
            inc_q       <= inc_n;
            start_q     <= start_n;
            swen_q      <= swen_n;
        end
    end

    // Next-state: MODE press wins; SET edits/blinks/times out; STOPWATCH pulses.
    always_comb begin
        mode_n      = mode_q;
        field_n     = field_q;
        tmo_n       = tmo_q;
        blink_cnt_n = blink_cnt_q;
        blink_n     = blink_q;
        inc_n       = 1'b0;
        start_n     = 1'b0;
        swen_n      = 1'b1;
        if (mode_ev) begin
            unique case (mode_q)
                MODE_CLOCK:     mode_n = MODE_SET;
                MODE_SET:       mode_n = MODE_STOPWATCH;
                MODE_STOPWATCH: mode_n = MODE_ALARM;
                MODE_ALARM:     mode_n = MODE_CLOCK;
            endcase
            field_n     = '0;
            tmo_n       = '0;
            blink_cnt_n = '0;
            blink_n     = 1'b0;
        end else begin
            case (mode_q)
                MODE_SET: begin
                    if (sel_ev) begin
                        field_n = field_q + 2'd1;
                    end
                    inc_n = inc_ev;
                    if (blink_cnt_q >= blink_max) begin
                        blink_n     = ~blink_q;
                        blink_cnt_n = '0;
                    end else begin
                        blink_cnt_n = blink_cnt_q + 1'b1;
                    end
                    if (any_ev) begin
                        tmo_n = '0;
                    end else if (tmo_q >= tmo_max) begin
                        mode_n      = MODE_CLOCK;
                        field_n     = '0;
                        tmo_n       = '0;
                        blink_cnt_n = '0;
                        blink_n     = 1'b0;
                    end else begin
                        tmo_n = tmo_q + 1'b1;
                    end
                end
                MODE_STOPWATCH: begin
                    start_n = sel_ev;
                    swen_n  = ~inc_ev;
                end
                default: ;
            endcase
        end
    end

    assign MODE      = mode_q;
    assign SET_FIELD = field_q;
    assign INC_PULSE = inc_q;
    assign SW_START  = start_q;
    assign SW_EN     = swen_q;
    assign BLINK     = blink_q;

endmodule
